// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: WIDTH bits resolved CHUNK bits per stage, carry registered between stages.
// Define PIPELINED_ADDSUB_OVF_EN to build signed-overflow reporting; otherwise ovf is tied to 0.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    // The whole pipe moves or holds as one, bubbles included.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SW   = WIDTH - k * CHUNK;
        localparam int RW   = (k + 1) * CHUNK;
        localparam bit LAST = (k == STAGES - 1);

        logic [SW-1:0]  a_src;
        logic [SW-1:0]  b_src;
        logic           ci;
        logic           vld_d;
        logic           vld_q;
        logic           cy_q;
        logic [CHUNK:0] sum_d;
        logic [RW-1:0]  res_d;
        logic [RW-1:0]  res_q;

        // Stage 0: fresh operands, inverted B and carry-in 1 for subtraction.
        if (k == 0) begin : g_in
            assign a_src = a;
            assign b_src = b_eff;
            assign ci    = sub;
            assign vld_d = in_valid;
            assign res_d = sum_d[CHUNK-1:0];
        end else begin : g_mid
            assign a_src = g_stg[k-1].g_rem.a_q;
            assign b_src = g_stg[k-1].g_rem.b_q;
            assign ci    = g_stg[k-1].cy_q;
            assign vld_d = g_stg[k-1].vld_q;
            assign res_d = {sum_d[CHUNK-1:0], g_stg[k-1].res_q};
        end

        assign sum_d = chunk_add(a_src[CHUNK-1:0], b_src[CHUNK-1:0], ci);

        // Only the operand bits above this stage's slice travel onward.
        if (!LAST) begin : g_rem
            logic [SW-CHUNK-1:0] a_q;
            logic [SW-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q <= a_src[SW-1:CHUNK];
                    b_q <= b_src[SW-1:CHUNK];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vld_d;
            end
        end

        always_ff @(posedge clk) begin
            if (LAST && rst) begin
                res_q <= '0;
                cy_q  <= 1'b0;
            end else if (adv) begin
                res_q <= res_d;
                cy_q  <= sum_d[CHUNK];
            end
        end
    end

    // Output boundary: results come straight from the final stage register.
    assign out_valid = g_stg[STAGES-1].vld_q;
    assign s         = g_stg[STAGES-1].res_q;
    assign c_out     = g_stg[STAGES-1].cy_q;

`ifdef PIPELINED_ADDSUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_d;
    logic ovf_q;

    assign a_msb = g_stg[STAGES-1].a_src[CHUNK-1];
    assign b_msb = g_stg[STAGES-1].b_src[CHUNK-1];
    assign ovf_d = (a_msb == b_msb) && (g_stg[STAGES-1].sum_d[CHUNK-1] != a_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (16/4, 32/8, 8/8) driven in lockstep, checked against an arithmetic model.
module tb_pipelined_addsub;
`ifdef PIPELINED_ADDSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        sub_i;
    logic [31:0] a_i;
    logic [31:0] b_i;

    logic        ir16, ov16, c16, o16;
    logic [15:0] s16;
    logic        ir32, ov32, c32, o32;
    logic [31:0] s32;
    logic        ir8, ov8, c8, o8;
    logic [7:0]  s8;

    int n_cmp = 0;
    int n_fail = 0;
    int cnt[3] = '{0, 0, 0};
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .a(a_i[15:0]), .b(b_i[15:0]), .sub(sub_i),
        .out_valid(ov16), .out_ready(out_ready), .s(s16), .c_out(c16), .ovf(o16));

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
        .a(a_i), .b(b_i), .sub(sub_i),
        .out_valid(ov32), .out_ready(out_ready), .s(s32), .c_out(c32), .ovf(o32));

    pipelined_addsub #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .a(a_i[7:0]), .b(b_i[7:0]), .sub(sub_i),
        .out_valid(ov8), .out_ready(out_ready), .s(s8), .c_out(c8), .ovf(o8));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Plain integer arithmetic: sum/difference mod 2^w, carry = no-borrow for subtraction,
    // overflow = true signed result outside the w-bit range.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic sv);
        exp_t   e;
        longint m, ua, ub, t, sa, sb, r, hi, lo;
        m  = (longint'(1) << w) - 1;
        ua = {32'b0, av} & m;
        ub = {32'b0, bv} & m;
        if (sv) begin
            t   = (ua - ub) & m;
            e.c = (ua >= ub);
        end else begin
            t   = ua + ub;
            e.c = ((t >> w) & 1) != 0;
            t   = t & m;
        end
        e.s = t[31:0];
        sa  = (ua > (m >> 1)) ? ua - (m + 1) : ua;
        sb  = (ub > (m >> 1)) ? ub - (m + 1) : ub;
        r   = sv ? sa - sb : sa + sb;
        hi  = m >> 1;
        lo  = -(hi + 1);
        e.o = OVF_ON && (r > hi || r < lo);
        return e;
    endfunction

    task automatic qpush(input int id, input exp_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int id, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{32'd0, 1'b0, 1'b0};
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic mon(input int id, input int w, input logic ir, input logic ov,
                       input logic [31:0] so, input logic co, input logic oo);
        exp_t  e;
        bit    ok;
        string nm;
        nm = (id == 0) ? "w16" : (id == 1) ? "w32" : "w8";
        if (ov && out_ready) begin
            qpop(id, ok, e);
            if (!ok) begin
                check({nm, "_unexpected_out_valid"}, 64'd1, 64'd0);
            end else begin
                check({nm, "_s"}, {32'b0, so}, {32'b0, e.s});
                check({nm, "_c_out"}, {63'b0, co}, {63'b0, e.c});
                check({nm, "_ovf"}, {63'b0, oo}, {63'b0, e.o});
                cnt[id]++;
            end
        end
        if (in_valid && ir) qpush(id, model(w, a_i, b_i, sub_i));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            mon(0, 16, ir16, ov16, {16'b0, s16}, c16, o16);
            mon(1, 32, ir32, ov32, s32, c32, o32);
            mon(2, 8, ir8, ov8, {24'b0, s8}, c8, o8);
        end
    end

    task automatic run_vec(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                           output int l16, output int l32, output int l8,
                           output logic [15:0] rs, output logic rc, output logic ro);
        a_i = av; b_i = bv; sub_i = sv; in_valid = 1'b1;
        l16 = 0; l32 = 0; l8 = 0; rs = '0; rc = 1'b0; ro = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (ov16 && l16 == 0) begin l16 = n; rs = s16; rc = c16; ro = o16; end
            if (ov32 && l32 == 0) l32 = n;
            if (ov8 && l8 == 0) l8 = n;
            if (l16 != 0 && l32 != 0 && l8 != 0) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[8];
        int          l16, l32, l8, base, cyc, i, guard;
        logic [15:0] rs;
        logic        rc, ro, acc;
        logic [31:0] sa[20];
        logic [31:0] sbv[20];
        logic        ss[20];

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[2] = '{16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", {61'b0, ov16, ov32, ov8}, 64'd0);
        check("rst_s16", {48'b0, s16}, 64'd0);
        check("rst_s32_s8", {24'b0, s32, s8}, 64'd0);
        check("rst_c_out", {61'b0, c16, c32, c8}, 64'd0);
        check("rst_ovf", {61'b0, o16, o32, o8}, 64'd0);
        check("rst_in_ready", {61'b0, ir16, ir32, ir8}, 64'd7);

        // Directed vectors with latency of every width.
        for (int k = 0; k < 8; k++) begin
            run_vec({16'b0, vt[k].a}, {16'b0, vt[k].b}, vt[k].sub, l16, l32, l8, rs, rc, ro);
            check($sformatf("vec%0d_s", k), {48'b0, rs}, {48'b0, vt[k].es});
            check($sformatf("vec%0d_c_out", k), {63'b0, rc}, {63'b0, vt[k].ec});
            check($sformatf("vec%0d_ovf", k), {63'b0, ro}, {63'b0, vt[k].eo && OVF_ON});
            check($sformatf("vec%0d_lat16", k), 64'(l16), 64'd4);
            check($sformatf("vec%0d_lat32", k), 64'(l32), 64'd4);
            check($sformatf("vec%0d_lat8", k), 64'(l8), 64'd1);
        end
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back stream with a 3-cycle output stall in the middle.
        for (int k = 0; k < 20; k++) begin
            sa[k] = $urandom; sbv[k] = $urandom; ss[k] = 1'($urandom_range(1));
        end
        base = cnt[0];
        cyc = 0;
        i = 0;
        while (i < 20 && cyc < 100) begin
            a_i = sa[i]; b_i = sbv[i]; sub_i = ss[i]; in_valid = 1'b1;
            out_ready = !(cyc >= 10 && cyc < 13);
            @(negedge clk);
            if (cyc >= 10 && cyc < 13) check($sformatf("stall_in_ready_c%0d", cyc), {63'b0, ir16}, 64'd0);
            if (cyc >= 13 && cnt[0] - base < 20) check($sformatf("nogap_c%0d", cyc), {63'b0, ov16}, 64'd1);
            acc = ir16;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (cnt[0] - base < 20 && guard < 30) begin
            @(negedge clk);
            check($sformatf("nogap_drain%0d", guard), {63'b0, ov16}, 64'd1);
            @(posedge clk); #1;
            guard++;
        end
        check("stream_result_count", 64'(cnt[0] - base), 64'd20);
        repeat (6) @(posedge clk);
        #1;

        // Reset with three operations in flight.
        for (int k = 0; k < 3; k++) begin
            a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom_range(1)); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", {61'b0, ov16, ov32, ov8}, 64'd0);
        check("midrst_s", {8'b0, s16, s32, s8}, 64'd0);
        check("midrst_in_ready", {63'b0, ir16}, 64'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_stale%0d", k), {61'b0, ov16, ov32, ov8}, 64'd0);
        end

        // Random traffic with random backpressure and corner operands.
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            sub_i = 1'($urandom_range(1));
            a_i = $urandom;
            b_i = $urandom;
            case ($urandom_range(7))
                0: a_i = 32'hFFFF_FFFF;
                1: b_i = 32'h0;
                2: begin a_i = 32'h7FFF_7F7F; b_i = 32'h0000_0101; end
                3: begin a_i = 32'h8000_8080; b_i = 32'h8000_8080; end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("final_queue16", 64'(q0.size()), 64'd0);
        check("final_queue32", 64'(q1.size()), 64'd0);
        check("final_queue8", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
